y_demux4_stream: RTL and testbench

- Registered 1-to-4 stream demultiplexer. It is the distribution counterpart of the 4-to-1 mux datapath.
- One input stream carries SIZE-bit words tagged with a 2-bit destination select. Each word is routed to one of four output channels.
- Each output channel has a one-entry holding register and its own valid/ready handshake.
- Used to fan one producer out to four independent consumers, for example per-unit result buses.

---
 rtl/y_demux4_stream.sv | 83 ++++++++
 tb/tb_y_demux4_stream.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/y_demux4_stream.sv
// Purpose : registered 1-to-4 stream demux; each input word is steered by in_sel into one of four one-entry channel registers.
// Latency : 1 cycle, from the accept edge to out_valid/out_data. There is no combinational in_data->out_data path.
// Backpress: in_ready follows only the selected channel (empty, or draining this cycle). Define YDEMUX_CNT_EN to add per-channel accept counters on port cnt.
module y_demux4_stream #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  input  logic [1:0]      in_sel,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [SIZE-1:0] out_data0,
  output logic [SIZE-1:0] out_data1,
  output logic [SIZE-1:0] out_data2,
  output logic [SIZE-1:0] out_data3
`ifdef YDEMUX_CNT_EN
  ,
  output logic [63:0]     cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  logic                acc;
  logic [3:0]          drn;
  logic [4*SIZE-1:0]   data_flat;

  // Gating with rst_n keeps the producer stalled while the block is held in reset.
  assign in_ready = rst_n & (~out_valid[in_sel] | out_ready[in_sel]);
  assign acc      = in_valid & in_ready;
  assign drn      = out_valid & out_ready;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    ch_state_t       state_q;
    logic [SIZE-1:0] dat_q;
    logic            fill;

    assign fill = acc & (in_sel == 2'(k));

    // Channel FSM: a fill wins over a drain, so a drain+fill in the same cycle stays FULL with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= EMPTY;
        dat_q   <= '0;
      end else if (fill) begin
        state_q <= FULL;
        dat_q   <= in_data;
      end else if (drn[k]) begin
        state_q <= EMPTY;
      end
    end

    assign out_valid[k]               = (state_q == FULL);
    assign data_flat[k*SIZE +: SIZE]  = dat_q;

`ifdef YDEMUX_CNT_EN
    logic [15:0] cnt_q;

    // Count the words accepted for this channel; wraps silently at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (fill) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end

    assign cnt[16*k +: 16] = cnt_q;
`endif
  end

  assign out_data0 = data_flat[0*SIZE +: SIZE];
  assign out_data1 = data_flat[1*SIZE +: SIZE];
  assign out_data2 = data_flat[2*SIZE +: SIZE];
  assign out_data3 = data_flat[3*SIZE +: SIZE];

endmodule

// File: tb/tb_y_demux4_stream.sv
// Bench for y_demux4_stream: per-channel queue model checked every negedge, plus directed literal checks.
module tb_y_demux4_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] dout [4];
`ifdef YDEMUX_CNT_EN
  logic [63:0] cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  // Model: undelivered words per channel, last delivered word, accept/deliver counts.
  logic [31:0] q    [4][$];
  logic [31:0] last [4];
  int          accepted  [4];
  int          delivered [4];

  y_demux4_stream #(.SIZE(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (dout[0]),
    .out_data1 (dout[1]),
    .out_data2 (dout[2]),
    .out_data3 (dout[3])
`ifdef YDEMUX_CNT_EN
    ,
    .cnt       (cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update: decide accept from pre-edge state, then drain, then fill.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        last[k] = '0;
      end
    end else begin
      bit a;
      a = in_valid && (q[in_sel].size() == 0 || out_ready[in_sel]);
      for (int k = 0; k < 4; k++)
        if (q[k].size() != 0 && out_ready[k]) last[k] = q[k].pop_front();
      if (a) begin
        q[in_sel].push_back(in_data);
        accepted[in_sel]++;
      end
    end
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      for (int k = 0; k < 4; k++) chk($sformatf("rst_out_data%0d", k), 64'(dout[k]), 64'h0);
    end else begin
      logic [3:0] ev;
      for (int k = 0; k < 4; k++) ev[k] = (q[k].size() != 0);
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("in_ready", 64'(in_ready), 64'(q[in_sel].size() == 0 || out_ready[in_sel]));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_data%0d", k), 64'(dout[k]), 64'(ev[k] ? q[k][0] : last[k]));
        if (out_valid[k] && out_ready[k]) delivered[k]++;
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin accepted[k] = 0; delivered[k] = 0; end
    #2;
    chk("por_in_ready", 64'(in_ready), 64'h0);
    chk("por_out_valid", 64'(out_valid), 64'h0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'h1);

    // Single word to channel 2, then selection-dependent ready.
    drive(1'b1, 2'd2, 32'hDEADBEEF, 4'h0);
    step();
    drive(1'b0, 2'd2, 32'h0, 4'h0);
    chk("t2_out_valid", 64'(out_valid), 64'h4);
    chk("t2_out_data2", 64'(dout[2]), 64'hDEADBEEF);
    #1;
    chk("t2_ready_sel2", 64'(in_ready), 64'h0);
    in_sel = 2'd1;
    #1;
    chk("t2_ready_sel1", 64'(in_ready), 64'h1);

    // Channel 3: fill with 1, then drain+fill with 2 in one cycle.
    step();
    drive(1'b1, 2'd3, 32'h1, 4'h0);
    step();
    drive(1'b1, 2'd3, 32'h2, 4'h8);
    #1;
    chk("t3_ready_drainfill", 64'(in_ready), 64'h1);
    chk("t3_data3_before", 64'(dout[3]), 64'h1);
    step();
    drive(1'b0, 2'd0, 32'h0, 4'h8);
    chk("t3_out_valid", 64'(out_valid), 64'hC);
    chk("t3_out_data3", 64'(dout[3]), 64'h2);
    step();
    drive(1'b0, 2'd0, 32'h0, 4'hF);
    step();
    chk("t3_drained", 64'(out_valid), 64'h0);

    // Channel 0 stalled for 5 cycles while channels 1..3 keep accepting.
    drive(1'b1, 2'd0, 32'hA0, 4'h0);
    step();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1'b1, 2'(c + 1), 32'hB0 + 32'(c), 4'h0);
      else       drive(1'b0, 2'd0, 32'h0, 4'h0);
      #1;
      if (c < 3) chk($sformatf("t4_ready_c%0d", c), 64'(in_ready), 64'h1);
      chk($sformatf("t4_data0_c%0d", c), 64'(dout[0]), 64'hA0);
      step();
    end
    chk("t4_out_valid", 64'(out_valid), 64'hF);
    chk("t4_out_data3", 64'(dout[3]), 64'hB2);

    // Asynchronous reset with out_valid = 1010.
    drive(1'b0, 2'd0, 32'h0, 4'hF);
    step();
    drive(1'b1, 2'd1, 32'h11, 4'h0);
    step();
    drive(1'b1, 2'd3, 32'h33, 4'h0);
    step();
    drive(1'b0, 2'd0, 32'h0, 4'h0);
    chk("t5_pre_out_valid", 64'(out_valid), 64'hA);
    rst_n = 1'b0;
    #1;
    chk("t5_async_out_valid", 64'(out_valid), 64'h0);
    chk("t5_async_in_ready", 64'(in_ready), 64'h0);
    chk("t5_async_data1", 64'(dout[1]), 64'h0);
    chk("t5_async_data3", 64'(dout[3]), 64'h0);
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin accepted[k] = 0; delivered[k] = 0; end

    // Random traffic with random backpressure.
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(3, 0) != 0), 2'($urandom_range(3, 0)), $urandom, 4'($urandom_range(15, 0)));
      step();
    end
    drive(1'b0, 2'd0, 32'h0, 4'hF);
    step(); step();
    for (int k = 0; k < 4; k++)
      chk($sformatf("rand_count_ch%0d", k), 64'(delivered[k]), 64'(accepted[k]));

`ifdef YDEMUX_CNT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 2'd1, 32'(i), 4'h2);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 32'(i), 4'h1);
      step();
    end
    drive(1'b0, 2'd0, 32'h0, 4'hF);
    step();
    chk("cnt_ch0", 64'(cnt[15:0]), 64'h3);
    chk("cnt_ch1", 64'(cnt[31:16]), 64'h1);
    chk("cnt_ch23", 64'(cnt[63:32]), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
